// File: rtl/skinny_sbox_pkg.sv
// Shared constants, FSM encoding and tag-pipe entry type for the Skinny-64
// masked S-box layer controller.
package skinny_sbox_pkg;

  localparam int SBOX_LATENCY = 9;
  localparam int SBOX_NIBBLES = 16;
  localparam int SBOX_RND_W   = 21;
  localparam int SBOX_TAG_W   = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } sbox_state_e;

  typedef struct packed {
    logic                  valid;
    logic [SBOX_TAG_W-1:0] tag;
  } tag_ent_t;

endpackage

// File: rtl/skinny_sbox_layer_ctrl_if.sv
// Link between the layer controller (master) and the attached masked S-box
// pipeline (slave).
interface skinny_sbox_layer_ctrl_if;
  import skinny_sbox_pkg::*;

  // Handshake: there is no valid/ready pair. The pipeline accepts one share pair
  // every cycle and returns its result exactly LATENCY cycles later; the master
  // alone knows which slots carry real work (a zero pair marks a bubble).
  logic [3:0]            sbox_s0_o;
  logic [3:0]            sbox_s1_o;
  logic [SBOX_RND_W-1:0] sbox_fresh_o;
  logic [3:0]            sbox_s0_i;
  logic [3:0]            sbox_s1_i;

  modport master (
    output sbox_s0_o, sbox_s1_o, sbox_fresh_o,
    input  sbox_s0_i, sbox_s1_i
  );

  modport slave (
    input  sbox_s0_o, sbox_s1_o, sbox_fresh_o,
    output sbox_s0_i, sbox_s1_i
  );

endinterface

// File: rtl/skinny_sbox_tag_pipe.sv
// LATENCY-deep shift register of {valid, tag} that shadows the S-box pipeline,
// so each returning result can be steered back to its nibble.
module skinny_sbox_tag_pipe
  import skinny_sbox_pkg::*;
#(
  parameter int LATENCY = SBOX_LATENCY
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push_i,
  input  logic [SBOX_TAG_W-1:0] tag_i,
  output logic                  valid_o,
  output logic [SBOX_TAG_W-1:0] tag_o,
  output logic                  any_valid_o
);

  tag_ent_t pipe_q [LATENCY];
  tag_ent_t pipe_d [LATENCY];

  always_comb begin
    any_valid_o = 1'b0;
    pipe_d[0]   = {push_i, tag_i};
    for (int i = 1; i < LATENCY; i++) begin
      pipe_d[i] = pipe_q[i-1];
    end
    for (int i = 0; i < LATENCY; i++) begin
      any_valid_o = any_valid_o | pipe_q[i].valid;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < LATENCY; i++) begin
        pipe_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < LATENCY; i++) begin
        pipe_q[i] <= pipe_d[i];
      end
    end
  end

  assign valid_o = pipe_q[LATENCY-1].valid;
  assign tag_o   = pipe_q[LATENCY-1].tag;

endmodule

// File: rtl/skinny_sbox_layer_ctrl.sv
// Feeds the nibbles of a two-share Skinny-64 state through one masked S-box
// pipeline and reassembles the result. Define SKINNY_SBOX_CTRL_ERR_EN to add rnd_err_o.
module skinny_sbox_layer_ctrl
  import skinny_sbox_pkg::*;
#(
  parameter int LATENCY = SBOX_LATENCY,
  parameter int NIBBLES = SBOX_NIBBLES
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start_i,
  input  logic [4*NIBBLES-1:0]   state_s0_i,
  input  logic [4*NIBBLES-1:0]   state_s1_i,
  input  logic [SBOX_RND_W-1:0]  rnd_i,
  input  logic                   rnd_valid_i,
  skinny_sbox_layer_ctrl_if.master sbox,
  output logic                   busy_o,
  output logic                   done_o,
  output logic [4*NIBBLES-1:0]   res_s0_o,
  output logic [4*NIBBLES-1:0]   res_s1_o,
  output sbox_state_e            state_dbg_o
`ifdef SKINNY_SBOX_CTRL_ERR_EN
  ,
  output logic                   rnd_err_o
`endif
);

  localparam int W = 4 * NIBBLES;
  localparam logic [SBOX_TAG_W-1:0] LAST_IDX = SBOX_TAG_W'(NIBBLES - 1);

  sbox_state_e           state_q, state_d;
  logic [SBOX_TAG_W-1:0] idx_q, idx_d;
  logic [W-1:0]          st_s0_q, st_s0_d;
  logic [W-1:0]          st_s1_q, st_s1_d;
  logic [W-1:0]          res_s0_q, res_s0_d;
  logic [W-1:0]          res_s1_q, res_s1_d;

  logic                  issue;
  logic                  wb_valid;
  logic [SBOX_TAG_W-1:0] wb_tag;
  logic                  any_valid;

  skinny_sbox_tag_pipe #(
    .LATENCY (LATENCY)
  ) u_tag_pipe (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_i      (issue),
    .tag_i       (idx_q),
    .valid_o     (wb_valid),
    .tag_o       (wb_tag),
    .any_valid_o (any_valid)
  );

  // DRAIN exits on an empty tag pipe: every token was issued before DRAIN,
  // so an empty pipe means every nibble has been written back.
  always_comb begin
    state_d = state_q;
    issue   = 1'b0;
    busy_o  = (state_q != IDLE);
    done_o  = (state_q == DONE);
    case (state_q)
      IDLE:    if (start_i) state_d = ISSUE;
      ISSUE: begin
        if (rnd_valid_i) begin
          issue = 1'b1;
          if (idx_q == LAST_IDX) state_d = DRAIN;
        end
      end
      DRAIN:   if (!any_valid) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    idx_d    = idx_q;
    st_s0_d  = st_s0_q;
    st_s1_d  = st_s1_q;
    res_s0_d = res_s0_q;
    res_s1_d = res_s1_q;
    if (state_q == IDLE && start_i) begin
      st_s0_d = state_s0_i;
      st_s1_d = state_s1_i;
      idx_d   = '0;
    end
    if (issue) idx_d = idx_q + SBOX_TAG_W'(1);
    if (wb_valid) begin
      res_s0_d[{wb_tag, 2'b00} +: 4] = sbox.sbox_s0_i;
      res_s1_d[{wb_tag, 2'b00} +: 4] = sbox.sbox_s1_i;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      st_s0_q  <= '0;
      st_s1_q  <= '0;
      res_s0_q <= '0;
      res_s1_q <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      st_s0_q  <= st_s0_d;
      st_s1_q  <= st_s1_d;
      res_s0_q <= res_s0_d;
      res_s1_q <= res_s1_d;
    end
  end

  // Each share gets its own mux; bubbles drive a zero pair.
  assign sbox.sbox_s0_o    = issue  ? st_s0_q[{idx_q, 2'b00} +: 4] : 4'h0;
  assign sbox.sbox_s1_o    = issue  ? st_s1_q[{idx_q, 2'b00} +: 4] : 4'h0;
  assign sbox.sbox_fresh_o = busy_o ? rnd_i : '0;

  assign res_s0_o    = res_s0_q;
  assign res_s1_o    = res_s1_q;
  assign state_dbg_o = state_q;

`ifdef SKINNY_SBOX_CTRL_ERR_EN
  // Stale randomness reaching gadgets that still hold live tokens.
  logic err_q, err_d;

  assign err_d = err_q | (!rnd_valid_i && any_valid);

  always_ff @(posedge clk) begin
    if (!rst_n) err_q <= 1'b0;
    else        err_q <= err_d;
  end

  assign rnd_err_o = err_q;
`endif

endmodule

// File: doc/skinny_sbox_layer_ctrl.md
SKINNY_SBOX_LAYER_CTRL -- requirements
Module: skinny_sbox_layer_ctrl

Interface
REQ-001 SHALL have parameter LATENCY, default 9, meaning the register depth of the attached masked S-box pipeline (HPC2, d=1).
REQ-002 SHALL have parameter NIBBLES, default 16, meaning the number of 4-bit nibbles per Skinny-64 state.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: synchronous, active-low reset.
REQ-005 SHALL have port start_i, input, 1 bit: request to process one state; sampled only in IDLE.
REQ-006 SHALL have ports state_s0_i and state_s1_i, input, 64 bits each: share 0 and share 1 of the input state; nibble i occupies bits [4i+3:4i].
REQ-007 SHALL have port rnd_i, input, 21 bits: fresh randomness for the S-box pipeline.
REQ-008 SHALL have port rnd_valid_i, input, 1 bit: rnd_i is fresh this cycle.
REQ-009 SHALL have ports sbox_s0_o and sbox_s1_o, output, 4 bits each: S-box input shares.
REQ-010 SHALL have port sbox_fresh_o, output, 21 bits: randomness forwarded to the S-box.
REQ-011 SHALL have ports sbox_s0_i and sbox_s1_i, input, 4 bits each: S-box output shares.
REQ-012 SHALL have ports busy_o and done_o, output, 1 bit each; done_o is a one-cycle pulse.
REQ-013 SHALL have ports res_s0_o and res_s1_o, output, 64 bits each: result shares, nibble layout as in REQ-006.

Function
REQ-014 SHALL implement FSM states IDLE, ISSUE, DRAIN and DONE.
REQ-015 IDLE with start_i=1 SHALL capture both input shares, clear the issue index, and go to ISSUE.
REQ-016 In ISSUE with rnd_valid_i=1, the block SHALL drive nibble[idx] of each share to the S-box, push a valid bit tagged idx into the tag pipe, and increment idx.
REQ-017 In ISSUE with rnd_valid_i=0, the block SHALL insert a bubble: no push, idx held, sbox_s0_o and sbox_s1_o driven to 0.
REQ-018 After the issue at idx=NIBBLES-1 the FSM SHALL go to DRAIN.
REQ-019 A token issued in cycle t SHALL be written into res_s0/res_s1 at its tag at the end of cycle t+LATENCY.
REQ-020 DRAIN SHALL go to DONE once all NIBBLES tokens have been written back.
REQ-021 DONE SHALL assert done_o for exactly one cycle and then return to IDLE.
REQ-022 Without bubbles, done_o SHALL rise exactly NIBBLES+LATENCY+1 cycles (26 by default) after start is accepted.
REQ-023 busy_o SHALL be 1 in ISSUE, DRAIN and DONE, and 0 in IDLE.
REQ-024 start_i while busy_o=1 SHALL be ignored.
REQ-025 res_s0_o and res_s1_o SHALL hold their values from DONE until the next write-back.
REQ-026 sbox_fresh_o SHALL equal rnd_i whenever busy_o=1, and SHALL be 0 otherwise.
REQ-027 Shares SHALL never be combined (XORed, muxed together or compared) anywhere in the block.

Reset
REQ-028 rst_n=0 SHALL force IDLE, idx=0, all tag-pipe valid bits=0, and busy_o, done_o, sbox_s0_o, sbox_s1_o, res_s0_o, res_s1_o and all captured-state registers to 0.
REQ-029 Reset mid-operation SHALL discard in-flight tokens; S-box outputs arriving afterwards SHALL NOT be written.
REQ-030 A start after reset SHALL complete normally.

Configuration
REQ-031 With SKINNY_SBOX_CTRL_ERR_EN defined, the block SHALL provide output rnd_err_o (1 bit, sticky, cleared only by reset).
REQ-032 rnd_err_o SHALL be set when rnd_valid_i=0 while any tag-pipe valid bit is 1 (stale randomness into in-flight gadgets).
REQ-033 Without SKINNY_SBOX_CTRL_ERR_EN, neither the rnd_err_o port nor its logic SHALL exist; behaviour is otherwise identical.

Structure
REQ-034 Package skinny_sbox_pkg SHALL hold SBOX_LATENCY=9, SBOX_NIBBLES=16, SBOX_RND_W=21 and the FSM state enum.
REQ-035 Sub-module skinny_sbox_tag_pipe SHALL implement the LATENCY-deep shift register of {valid, 4-bit tag} with synchronous clear.

Verification
REQ-036 s0=0x0000000000000000, s1=0x0, rnd_valid_i=1 constant -> res_s0^res_s1=0xCCCCCCCCCCCCCCCC; done_o 26 cycles after start.
REQ-037 s0^s1=0x0123456789ABCDEF with random share split -> res_s0^res_s1=0xC6901A2B385D4E7F.
REQ-038 rnd_valid_i low for 3 cycles during ISSUE -> correct result; done_o at cycle 29; ERR_EN build shows rnd_err_o=1.
REQ-039 start_i pulsed at cycles 5 and 10 after the first start -> single done_o; result of the first state only.
REQ-040 rst_n=0 at cycle 12, then a new start with 0x0 -> result 0xCCCCCCCCCCCCCCCC, with no writes from stale tokens.
REQ-041 Back-to-back starts (start on the cycle after done_o) -> both results correct; busy_o low for exactly one cycle between them.
